// File: rtl/systolic_mm_engine_if.sv
// Operand/result bus of the systolic matrix-multiply engine: job control,
// operand beats and the flattened result matrix.
interface systolic_mm_engine_if #(
    parameter int SIZE     = 8,
    parameter int I_BITS   = 8,
    parameter int O_BITS   = 19,
    parameter int DIM_BITS = $clog2(SIZE) + 1
);
    // Handshake: a job starts when i_start is seen while o_busy is low; an
    // operand beat transfers on a rising edge where o_ready && i_valid, and
    // the master may hold or drop i_valid freely between beats.
    logic                          i_start;
    logic [DIM_BITS-1:0]           i_dim;
    logic                          i_signed;
    logic                          i_valid;
    logic [SIZE*I_BITS-1:0]        i_a_full;
    logic [SIZE*I_BITS-1:0]        i_b_full;
    logic                          o_ready;
    logic                          o_busy;
    logic                          o_done;
    logic                          o_sat;
    logic [SIZE*SIZE*O_BITS-1:0]   o_c_full;
    logic [1:0]                    dbg_state;

    modport master (
        output i_start, i_dim, i_signed, i_valid, i_a_full, i_b_full,
        input  o_ready, o_busy, o_done, o_sat, o_c_full, dbg_state
    );

    modport slave (
        input  i_start, i_dim, i_signed, i_valid, i_a_full, i_b_full,
        output o_ready, o_busy, o_done, o_sat, o_c_full, dbg_state
    );
endinterface

// File: rtl/systolic_mm_engine.sv
// SIZE x SIZE output-stationary systolic array computing C = A*B for an active
// dimension N, with internal operand skew and saturating accumulators.
module systolic_mm_engine #(
    parameter int SIZE     = 8,
    parameter int I_BITS   = 8,
    parameter int O_BITS   = 19,
    parameter int DIM_BITS = $clog2(SIZE) + 1
) (
    input logic                  i_clock,
    input logic                  i_reset,
    systolic_mm_engine_if.slave  bus
);
    localparam int CW = DIM_BITS + 1;
    localparam logic [DIM_BITS-1:0] SIZE_D = DIM_BITS'(SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;
    logic start_accept, advance, load_last;
    logic ready, busy, done;

    logic [DIM_BITS-1:0] n_r, dim_res;
    logic [CW-1:0]       n_ext, beat_cnt, drain_cnt;
    logic                sgn_r, sat_r;

    logic [I_BITS-1:0] a_lane  [SIZE];
    logic [I_BITS-1:0] b_lane  [SIZE];
    logic [I_BITS-1:0] a_skew  [SIZE];
    logic [I_BITS-1:0] b_skew  [SIZE];
    logic [I_BITS-1:0] a_pe    [SIZE][SIZE];
    logic [I_BITS-1:0] b_pe    [SIZE][SIZE];
    logic [I_BITS-1:0] a_reg   [SIZE][SIZE-1];
    logic [I_BITS-1:0] b_reg   [SIZE-1][SIZE];
    logic [O_BITS-1:0] acc     [SIZE][SIZE];
    logic [O_BITS-1:0] acc_nx  [SIZE][SIZE];
    logic [SIZE*SIZE-1:0]        clamp_v;
    logic [SIZE*SIZE*O_BITS-1:0] c_full;

    assign dim_res = (bus.i_dim == '0 || bus.i_dim > SIZE_D) ? SIZE_D : bus.i_dim;
    assign n_ext   = {1'b0, n_r};

    // Returns {clamped, new_acc}: product widened to O_BITS+1 so the clamp
    // can be decided from the top two bits of the sum.
    function automatic logic [O_BITS:0] mac(input logic [O_BITS-1:0] acc_in,
                                            input logic [I_BITS-1:0] a,
                                            input logic [I_BITS-1:0] b,
                                            input logic sgn);
        logic [2*I_BITS-1:0] ax, bx, prod;
        logic [O_BITS:0]     pe, ae, sum;
        logic [O_BITS-1:0]   res;
        logic                clamp;
        ax    = {{I_BITS{sgn & a[I_BITS-1]}}, a};
        bx    = {{I_BITS{sgn & b[I_BITS-1]}}, b};
        prod  = ax * bx;
        pe    = {{(O_BITS+1-2*I_BITS){sgn & prod[2*I_BITS-1]}}, prod};
        ae    = {sgn & acc_in[O_BITS-1], acc_in};
        sum   = ae + pe;
        clamp = 1'b0;
        res   = sum[O_BITS-1:0];
        if (sgn) begin
            if (sum[O_BITS] != sum[O_BITS-1]) begin
                clamp = 1'b1;
                res   = sum[O_BITS] ? {1'b1, {(O_BITS-1){1'b0}}} : {1'b0, {(O_BITS-1){1'b1}}};
            end
        end else if (sum[O_BITS]) begin
            clamp = 1'b1;
            res   = '1;
        end
        return {clamp, res};
    endfunction

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        start_accept = 1'b0;
        advance      = 1'b0;
        load_last    = 1'b0;
        ready        = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.i_start) begin
                    start_accept = 1'b1;
                    state_nx     = LOAD;
                end
            end
            LOAD: begin
                ready = 1'b1;
                if (bus.i_valid) begin
                    advance = 1'b1;
                    if (beat_cnt == n_ext - CW'(1)) begin
                        load_last = 1'b1;
                        state_nx  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                advance = 1'b1;
                if (drain_cnt == '0) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            n_r       <= '0;
            sgn_r     <= 1'b0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (start_accept) begin
                n_r      <= dim_res;
                sgn_r    <= bus.i_signed;
                beat_cnt <= '0;
            end
            if (state == LOAD && bus.i_valid) begin
                beat_cnt <= beat_cnt + CW'(1);
                if (load_last) drain_cnt <= {n_r, 1'b0} - CW'(2);
            end
            if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - CW'(1);
        end
    end

    // Row i of A and column j of B enter through an i-deep (j-deep) delay line
    // so that A[i][k] and B[k][j] meet in PE(i,j) on the same advance.
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
        localparam logic [DIM_BITS-1:0] LANE = DIM_BITS'(gi);
        assign a_lane[gi] = (state == LOAD && LANE < n_r) ? bus.i_a_full[gi*I_BITS +: I_BITS] : '0;
        assign b_lane[gi] = (state == LOAD && LANE < n_r) ? bus.i_b_full[gi*I_BITS +: I_BITS] : '0;
        if (gi == 0) begin : g_direct
            assign a_skew[gi] = a_lane[gi];
            assign b_skew[gi] = b_lane[gi];
        end else begin : g_delay
            logic [I_BITS-1:0] a_sr [gi];
            logic [I_BITS-1:0] b_sr [gi];
            always_ff @(posedge i_clock) begin
                if (i_reset || start_accept) begin
                    for (int d = 0; d < gi; d++) begin
                        a_sr[d] <= '0;
                        b_sr[d] <= '0;
                    end
                end else if (advance) begin
                    a_sr[0] <= a_lane[gi];
                    b_sr[0] <= b_lane[gi];
                    for (int d = 1; d < gi; d++) begin
                        a_sr[d] <= a_sr[d-1];
                        b_sr[d] <= b_sr[d-1];
                    end
                end
            end
            assign a_skew[gi] = a_sr[gi-1];
            assign b_skew[gi] = b_sr[gi-1];
        end
    end

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign a_pe[gi][gj] = a_skew[gi];
            end else begin : g_a_inner
                assign a_pe[gi][gj] = a_reg[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_pe[gi][gj] = b_skew[gj];
            end else begin : g_b_inner
                assign b_pe[gi][gj] = b_reg[gi-1][gj];
            end
            assign {clamp_v[gi*SIZE+gj], acc_nx[gi][gj]} =
                mac(acc[gi][gj], a_pe[gi][gj], b_pe[gi][gj], sgn_r);
            assign c_full[(gi*SIZE+gj)*O_BITS +: O_BITS] = acc[gi][gj];
        end
    end

    // A new job also flushes the pass-through registers: columns beyond a
    // short job's N can still hold operands that never met a live B lane.
    always_ff @(posedge i_clock) begin
        if (i_reset || start_accept) begin
            sat_r <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) acc[i][j] <= '0;
                for (int j = 0; j < SIZE-1; j++) a_reg[i][j] <= '0;
            end
            for (int i = 0; i < SIZE-1; i++)
                for (int j = 0; j < SIZE; j++) b_reg[i][j] <= '0;
        end else if (advance) begin
            sat_r <= sat_r | (|clamp_v);
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) acc[i][j] <= acc_nx[i][j];
                for (int j = 0; j < SIZE-1; j++) a_reg[i][j] <= a_pe[i][j];
            end
            for (int i = 0; i < SIZE-1; i++)
                for (int j = 0; j < SIZE; j++) b_reg[i][j] <= b_pe[i][j];
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_busy    = busy;
    assign bus.o_done    = done;
    assign bus.o_sat     = sat_r;
    assign bus.o_c_full  = c_full;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: two instances (19-bit and 16-bit accumulators)
// share one stimulus stream; per-instance scoreboards check every o_done.
module tb_systolic_mm_engine;
    localparam int SZ = 8;
    localparam int C19_W = SZ*SZ*19;
    localparam int C16_W = SZ*SZ*16;

    typedef struct packed { logic [C19_W-1:0] c; logic sat; logic [31:0] cyc; } exp19_t;
    typedef struct packed { logic [C16_W-1:0] c; logic sat; logic [31:0] cyc; } exp16_t;

    logic clk = 1'b0;
    logic rst, start, sgn, valid;
    logic [3:0] dim;
    logic [SZ*8-1:0] a_bus, b_bus;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    exp19_t exp19_q[$];
    exp16_t exp16_q[$];
    logic [7:0] a_m [SZ][SZ];
    logic [7:0] b_m [SZ][SZ];
    longint res [SZ][SZ];
    bit res_sat;

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_mm_engine_if #(.SIZE(SZ), .I_BITS(8), .O_BITS(19), .DIM_BITS(4)) bus19();
    systolic_mm_engine_if #(.SIZE(SZ), .I_BITS(8), .O_BITS(16), .DIM_BITS(4)) bus16();

    assign bus19.i_start = start;  assign bus16.i_start = start;
    assign bus19.i_dim = dim;      assign bus16.i_dim = dim;
    assign bus19.i_signed = sgn;   assign bus16.i_signed = sgn;
    assign bus19.i_valid = valid;  assign bus16.i_valid = valid;
    assign bus19.i_a_full = a_bus; assign bus16.i_a_full = a_bus;
    assign bus19.i_b_full = b_bus; assign bus16.i_b_full = b_bus;

    systolic_mm_engine #(.SIZE(SZ), .I_BITS(8), .O_BITS(19), .DIM_BITS(4)) dut19 (
        .i_clock(clk), .i_reset(rst), .bus(bus19));
    systolic_mm_engine #(.SIZE(SZ), .I_BITS(8), .O_BITS(16), .DIM_BITS(4)) dut16 (
        .i_clock(clk), .i_reset(rst), .bus(bus16));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, act, exp);
        end
    endtask

    function automatic logic [18:0] lane19(input int i, input int j);
        return bus19.o_c_full[(i*SZ+j)*19 +: 19];
    endfunction

    function automatic logic [15:0] lane16(input int i, input int j);
        return bus16.o_c_full[(i*SZ+j)*16 +: 16];
    endfunction

    // Reference: plain matrix product, accumulator clamped after every k.
    task automatic ref_mm(input int n, input bit s, input int ob);
        longint lo, hi, acc, p;
        res_sat = 1'b0;
        hi = s ? ((longint'(1) << (ob-1)) - 1) : ((longint'(1) << ob) - 1);
        lo = s ? -(longint'(1) << (ob-1)) : longint'(0);
        for (int i = 0; i < SZ; i++) begin
            for (int j = 0; j < SZ; j++) begin
                acc = 0;
                if (i < n && j < n) begin
                    for (int k = 0; k < n; k++) begin
                        p = s ? longint'($signed(a_m[i][k])) * longint'($signed(b_m[k][j]))
                              : longint'(a_m[i][k]) * longint'(b_m[k][j]);
                        acc = acc + p;
                        if (acc > hi) begin acc = hi; res_sat = 1'b1; end
                        if (acc < lo) begin acc = lo; res_sat = 1'b1; end
                    end
                end
                res[i][j] = acc;
            end
        end
    endtask

    task automatic push_exp(input int n, input bit s, input int done_cyc);
        exp19_t e19;
        exp16_t e16;
        ref_mm(n, s, 19);
        e19.c = '0;
        for (int l = 0; l < SZ*SZ; l++) e19.c[l*19 +: 19] = res[l/SZ][l%SZ][18:0];
        e19.sat = res_sat;
        e19.cyc = 32'(done_cyc);
        exp19_q.push_back(e19);
        ref_mm(n, s, 16);
        e16.c = '0;
        for (int l = 0; l < SZ*SZ; l++) e16.c[l*16 +: 16] = res[l/SZ][l%SZ][15:0];
        e16.sat = res_sat;
        e16.cyc = 32'(done_cyc);
        exp16_q.push_back(e16);
    endtask

    task automatic fill_random();
        for (int i = 0; i < SZ; i++)
            for (int j = 0; j < SZ; j++) begin
                a_m[i][j] = 8'($urandom_range(0, 255));
                b_m[i][j] = 8'($urandom_range(0, 255));
            end
    endtask

    task automatic drive_beat(input int n, input int k);
        for (int l = 0; l < SZ; l++) begin
            a_bus[l*8 +: 8] = (l < n) ? a_m[l][k] : 8'($urandom_range(1, 255));
            b_bus[l*8 +: 8] = (l < n) ? b_m[k][l] : 8'($urandom_range(1, 255));
        end
    endtask

    // One job: start (with a stray beat that must not count), N beats with
    // optional 2-cycle gaps, optional ignored start pulses, then wait for done.
    task automatic run_job(input int dim_in, input bit s, input bit gaps, input bit poke);
        int n, ngap, w;
        n    = (dim_in == 0 || dim_in > SZ) ? SZ : dim_in;
        ngap = gaps ? 2*(n-1) : 0;
        @(negedge clk);
        start = 1'b1; dim = 4'(dim_in); sgn = s; valid = 1'b1;
        a_bus = 64'($urandom()); b_bus = 64'($urandom());
        push_exp(n, s, cyc + 1 + 3*n - 1 + ngap);
        @(negedge clk);
        start = 1'b0; valid = 1'b0; dim = 4'd1; sgn = ~s;
        chk("ready_after_start", 64'(bus19.o_ready), 64'd1);
        chk("busy_after_start", 64'(bus16.o_busy), 64'd1);
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) begin
                valid = 1'b0;
                repeat (2) @(negedge clk);
            end
            drive_beat(n, k);
            valid = 1'b1;
            if (poke && k == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        valid = 1'b0;
        a_bus = 64'($urandom()); b_bus = 64'($urandom());
        chk("ready_in_drain", 64'(bus19.o_ready), 64'd0);
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        w = 0;
        while (!bus19.o_done && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dim %0d no o_done within 100 cycles", dim_in);
        end
        @(negedge clk);
        chk("busy_after_done", 64'(bus19.o_busy), 64'd0);
    endtask

    // scoreboard monitors
    always @(negedge clk) begin : mon19
        exp19_t e;
        int bad;
        if (bus19.o_done) begin
            checks++;
            if (exp19_q.size() == 0) begin
                errors++;
                $display("FAIL done19 unexpected o_done at cycle %0d", cyc);
            end else begin
                e = exp19_q.pop_front();
                bad = -1;
                for (int l = 0; l < SZ*SZ; l++)
                    if (bad < 0 && bus19.o_c_full[l*19 +: 19] !== e.c[l*19 +: 19]) bad = l;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL c19 lane %0d got %0d exp %0d", bad,
                             bus19.o_c_full[bad*19 +: 19], e.c[bad*19 +: 19]);
                end
                chk("sat19", 64'(bus19.o_sat), 64'(e.sat));
                chk("done19_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp16_t e;
        int bad;
        if (bus16.o_done) begin
            checks++;
            if (exp16_q.size() == 0) begin
                errors++;
                $display("FAIL done16 unexpected o_done at cycle %0d", cyc);
            end else begin
                e = exp16_q.pop_front();
                bad = -1;
                for (int l = 0; l < SZ*SZ; l++)
                    if (bad < 0 && bus16.o_c_full[l*16 +: 16] !== e.c[l*16 +: 16]) bad = l;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL c16 lane %0d got %0d exp %0d", bad,
                             bus16.o_c_full[bad*16 +: 16], e.c[bad*16 +: 16]);
                end
                chk("sat16", 64'(bus16.o_sat), 64'(e.sat));
                chk("done16_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; dim = '0; sgn = 1'b0;
        a_bus = '0; b_bus = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus19.o_ready), 64'd0);
        chk("rst_busy", 64'(bus19.o_busy), 64'd0);
        chk("rst_done", 64'(bus19.o_done), 64'd0);
        chk("rst_sat", 64'(bus16.o_sat), 64'd0);
        chk("rst_c19_zero", 64'(|bus19.o_c_full), 64'd0);
        chk("rst_state", 64'(bus19.dbg_state), 64'd0);
        rst = 1'b0;

        // N=2 unsigned, A=[[1,2],[3,4]], B=identity
        for (int i = 0; i < SZ; i++)
            for (int j = 0; j < SZ; j++) begin a_m[i][j] = 8'd0; b_m[i][j] = 8'd0; end
        a_m[0][0] = 8'd1; a_m[0][1] = 8'd2; a_m[1][0] = 8'd3; a_m[1][1] = 8'd4;
        b_m[0][0] = 8'd1; b_m[1][1] = 8'd1;
        run_job(2, 1'b0, 1'b0, 1'b0);
        chk("t1_c00", 64'(lane19(0, 0)), 64'd1);
        chk("t1_c01", 64'(lane19(0, 1)), 64'd2);
        chk("t1_c10", 64'(lane19(1, 0)), 64'd3);
        chk("t1_c11", 64'(lane19(1, 1)), 64'd4);
        chk("t1_c22", 64'(lane19(2, 2)), 64'd0);

        // N=8 signed, all -128: 8 * 16384 = 131072; 16-bit lanes clamp at 32767
        for (int i = 0; i < SZ; i++)
            for (int j = 0; j < SZ; j++) begin a_m[i][j] = 8'h80; b_m[i][j] = 8'h80; end
        run_job(8, 1'b1, 1'b0, 1'b0);
        chk("t2_c77_19", 64'(lane19(7, 7)), 64'd131072);
        chk("t2_c03_19", 64'(lane19(0, 3)), 64'd131072);
        chk("t2_c00_16", 64'(lane16(0, 0)), 64'd32767);
        chk("t2_sat16", 64'(bus16.o_sat), 64'd1);

        // i_dim=0 as N=8, unsigned 255: 8 * 65025 = 520200; 16-bit lanes -> 65535
        for (int i = 0; i < SZ; i++)
            for (int j = 0; j < SZ; j++) begin a_m[i][j] = 8'hFF; b_m[i][j] = 8'hFF; end
        run_job(0, 1'b0, 1'b0, 1'b0);
        chk("t3_c55_19", 64'(lane19(5, 5)), 64'd520200);
        chk("t3_sat19", 64'(bus19.o_sat), 64'd0);
        chk("t3_c12_16", 64'(lane16(1, 2)), 64'd65535);
        chk("t3_sat16", 64'(bus16.o_sat), 64'd1);

        // N=4 random signed with 1,0,0,1,... valid pattern
        fill_random();
        run_job(4, 1'b1, 1'b1, 1'b0);

        // N=3 random unsigned, start pulses during LOAD and DRAIN ignored
        fill_random();
        run_job(3, 1'b0, 1'b0, 1'b1);
        chk("t5_c33_zero", 64'(lane19(3, 3)), 64'd0);

        // i_dim above SIZE resolves to 8
        fill_random();
        run_job(9, 1'b1, 1'b0, 1'b0);

        // reset on the 2nd LOAD beat
        fill_random();
        a_m[0][0] = 8'd5; b_m[0][0] = 8'd7;
        @(negedge clk);
        start = 1'b1; dim = 4'd2; sgn = 1'b0; valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        drive_beat(2, 0); valid = 1'b1;
        @(negedge clk);
        drive_beat(2, 1); rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        chk("rst_mid_busy19", 64'(bus19.o_busy), 64'd0);
        chk("rst_mid_ready19", 64'(bus19.o_ready), 64'd0);
        chk("rst_mid_c19_zero", 64'(|bus19.o_c_full), 64'd0);
        chk("rst_mid_c16_zero", 64'(|bus16.o_c_full), 64'd0);
        chk("rst_mid_state16", 64'(bus16.dbg_state), 64'd0);

        fill_random();
        run_job(2, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue19_empty", 64'(exp19_q.size()), 64'd0);
        chk("queue16_empty", 64'(exp16_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
